// File: rtl/game_pkg.sv
// Shared definitions for the game player and the game core it drives.
//   state_t     : player FSM states
//   MV_*        : move codes driven on controlValue
//   WHO_*       : match winner codes reported by the core's round counter
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MV_UP1 = 2'b00;
    localparam logic [1:0] MV_UP2 = 2'b01;
    localparam logic [1:0] MV_DN1 = 2'b10;
    localparam logic [1:0] MV_DN2 = 2'b11;

    localparam logic [1:0] WHO_NONE    = 2'b00;
    localparam logic [1:0] WHO_PLAYER1 = 2'b01;
    localparam logic [1:0] WHO_PLAYER2 = 2'b10;
    localparam logic [1:0] WHO_DRAW    = 2'b11;

endpackage

// File: rtl/game_player_sat_score_counter.sv
// Saturating round counter used for the win and loss tallies.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear (has priority over inc)
//   inc        : add one, stops at TARGET
//   count      : current tally
module sat_score_counter #(
    parameter  int TARGET = 15,
    localparam int SW     = $clog2(TARGET + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [SW-1:0] count
);

    logic [SW-1:0] count_q;
    logic [SW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != SW'(TARGET))) begin
            count_d = count_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/game_player.sv
// Player-side driver for the game core: accepts moves over valid/ready,
// pulses INIT to (re)load the core each round, keeps win/loss tallies and
// reports the match winner once the core signals game over.
//   clk, rst              : clock, async active-low reset
//   start, seed           : begin a match with this per-round start value
//   mv_valid/mv_code/mv_ready : upstream move handshake
//   controlValue, initialValue, INIT : to core
//   WINNER, LOSER, GAMEOVER, WHO     : from core
//   round_done, score_w, score_l, match_over, match_who : status
//   ack                   : leave DONE
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | INIT pulse to the core
// PLAY  | accepting moves, watching for round end
// DONE  | match finished, result held until ack
module game_player
    import game_pkg::*;
#(
    parameter  int mmcINPUT = 4,
    parameter  int TARGET   = 15,
    localparam int SW       = $clog2(TARGET + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [mmcINPUT-1:0] seed,
    input  logic                mv_valid,
    input  logic [1:0]          mv_code,
    output logic                mv_ready,
    output logic [1:0]          controlValue,
    output logic [mmcINPUT-1:0] initialValue,
    output logic                INIT,
    input  logic                WINNER,
    input  logic                LOSER,
    input  logic                GAMEOVER,
    input  logic [1:0]          WHO,
    output logic                round_done,
    output logic [SW-1:0]       score_w,
    output logic [SW-1:0]       score_l,
    output logic                match_over,
    output logic [1:0]          match_who,
    input  logic                ack
);

    state_t                state_q, state_d;
    logic [1:0]            cv_q, cv_d;
    logic [mmcINPUT-1:0]   iv_q, iv_d;
    logic                  init_q, init_d;
    logic                  round_done_q, round_done_d;
    logic                  match_over_q, match_over_d;
    logic [1:0]            who_q, who_d;
    logic                  score_clr;
    logic                  inc_w;
    logic                  inc_l;
    logic                  round_end;

    always_comb begin
        state_d      = state_q;
        cv_d         = cv_q;
        iv_d         = iv_q;
        who_d        = who_q;
        round_done_d = 1'b0;
        score_clr    = 1'b0;
        inc_w        = 1'b0;
        inc_l        = 1'b0;
        round_end    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    iv_d      = seed;
                    cv_d      = MV_UP1;
                    who_d     = WHO_NONE;
                    score_clr = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // a move arriving in the same cycle as a round end still lands
                if (mv_valid) begin
                    cv_d = mv_code;
                end
                // simultaneous WINNER and LOSER counts as a win only
                inc_w        = WINNER;
                inc_l        = LOSER && !WINNER;
                round_end    = WINNER || LOSER;
                round_done_d = round_end;
                if (GAMEOVER) begin
                    who_d   = WHO;
                    state_d = ST_DONE;
                end else if (round_end) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // registered outputs follow the state being entered
        init_d       = (state_d == ST_LOAD);
        match_over_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cv_q         <= '0;
            iv_q         <= '0;
            init_q       <= 1'b0;
            round_done_q <= 1'b0;
            match_over_q <= 1'b0;
            who_q        <= '0;
        end else begin
            state_q      <= state_d;
            cv_q         <= cv_d;
            iv_q         <= iv_d;
            init_q       <= init_d;
            round_done_q <= round_done_d;
            match_over_q <= match_over_d;
            who_q        <= who_d;
        end
    end

    sat_score_counter #(.TARGET(TARGET)) u_score_w (
        .clk   (clk),
        .rst_n (rst),
        .clear (score_clr),
        .inc   (inc_w),
        .count (score_w)
    );

    sat_score_counter #(.TARGET(TARGET)) u_score_l (
        .clk   (clk),
        .rst_n (rst),
        .clear (score_clr),
        .inc   (inc_l),
        .count (score_l)
    );

    assign mv_ready     = (state_q == ST_PLAY);
    assign controlValue = cv_q;
    assign initialValue = iv_q;
    assign INIT         = init_q;
    assign round_done   = round_done_q;
    assign match_over   = match_over_q;
    assign match_who    = who_q;

endmodule
